gayle_ide_cycle: RTL and testbench

- Bus-cycle front end for the Gayle/IDE window: decodes the CPU address, drives the IDE chip selects and read/write strobes with programmable PIO timing, and generates DTACK_N.
- Produces the active-low CS that the Gayle register block consumes.
- Sits between the 68k bus (AS_N/DS_N/RW/address) and both the IDE connector and the Gayle register block.

---
 rtl/gayle_pkg.sv | 30 +++
 rtl/gayle_ide_cycle_if.sv | 32 +++
 rtl/gayle_cyc_counter.sv | 28 ++
 rtl/gayle_ide_cycle.sv | 230 +++++++++++++++++++++++
 tb/tb_gayle_ide_cycle.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/gayle_pkg.sv
// Shared constants for the Gayle/IDE bus-cycle front end: FSM encoding,
// address-match values and timing-parameter limits.
package gayle_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_REG     = 3'd1;
  localparam logic [2:0] ST_SETUP   = 3'd2;
  localparam logic [2:0] ST_STROBE  = 3'd3;
  localparam logic [2:0] ST_RD_ACK  = 3'd4;
  localparam logic [2:0] ST_WR_HOLD = 3'd5;
  localparam logic [2:0] ST_WR_ACK  = 3'd6;
  localparam logic [2:0] ST_RECOVER = 3'd7;

  localparam logic [7:0]  IDE_HI_MATCH  = 8'hDA;
  localparam logic [2:0]  IDE_MID_MATCH = 3'b001;
  localparam logic [11:0] REG_ALT_MATCH = 12'hDE1;

  localparam int CYC_MIN      = 1;
  localparam int CYC_MAX      = 255;
  localparam int REG_WAIT_MAX = 15;

  // Out-of-range timing values are pulled back into range so the counter
  // never loads 0 (which would never reach its terminal count).
  function automatic logic [7:0] clamp_cyc(input int val, input int hi);
    int lim;
    lim = (val < CYC_MIN) ? CYC_MIN : ((val > hi) ? hi : val);
    return lim[7:0];
  endfunction

endpackage

// File: rtl/gayle_ide_cycle_if.sv
// 68k bus / IDE connector / Gayle-select signal bundle for the IDE cycle
// front end. The CPU side is the master; the cycle generator is the slave.
interface gayle_ide_cycle_if;

  logic        AS_N;
  logic        DS_N;
  logic        RW;
  logic [11:0] A;
  logic        IORDY;

  logic        GAYLE_CS_N;
  logic        IDE_CS0_N;
  logic        IDE_CS1_N;
  logic        IDE_RD_N;
  logic        IDE_WR_N;
  logic        BUF_OE_N;
  logic        DTACK_N;
  logic        TIMEOUT;

  modport master (
    output AS_N, DS_N, RW, A, IORDY,
    input  GAYLE_CS_N, IDE_CS0_N, IDE_CS1_N, IDE_RD_N, IDE_WR_N,
           BUF_OE_N, DTACK_N, TIMEOUT
  );

  modport slave (
    input  AS_N, DS_N, RW, A, IORDY,
    output GAYLE_CS_N, IDE_CS0_N, IDE_CS1_N, IDE_RD_N, IDE_WR_N,
           BUF_OE_N, DTACK_N, TIMEOUT
  );

endinterface

// File: rtl/gayle_cyc_counter.sv
// Loadable 8-bit down-counter; saturates at 1, which is also its terminal
// count, so a state may linger (IORDY stretch, AS_N wait) without wrapping.
module gayle_cyc_counter (
  input  logic       CLKCPU,
  input  logic       RESET,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       tc
);

  logic [7:0] cnt_r;

  // Load on state entry, otherwise count down to 1 and hold there.
  always_ff @(posedge CLKCPU or posedge RESET) begin
    if (RESET) begin
      cnt_r <= 8'd0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r > 8'd1) begin
      cnt_r <= cnt_r - 8'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tc = (cnt_r == 8'd1);

endmodule

// File: rtl/gayle_ide_cycle.sv
// Gayle/IDE bus-cycle front end: address decode, IDE chip selects and PIO
// strobes with programmable timing, Gayle register select and DTACK_N.
module gayle_ide_cycle
  import gayle_pkg::*;
#(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 6,
  parameter int HOLD_CYC   = 2,
  parameter int REG_WAIT   = 1,
  parameter int IORDY_TMO  = 64
) (
  input  logic             CLKCPU,
  input  logic             RESET,
  gayle_ide_cycle_if.slave bus
);

  localparam logic [7:0] SETUP_LD  = clamp_cyc(SETUP_CYC, CYC_MAX);
  localparam logic [7:0] STROBE_LD = clamp_cyc(STROBE_CYC, CYC_MAX);
  localparam logic [7:0] HOLD_LD   = clamp_cyc(HOLD_CYC, CYC_MAX);
  localparam logic [7:0] REG_LD    = clamp_cyc(REG_WAIT, REG_WAIT_MAX);
  localparam logic [7:0] TMO_LD    = clamp_cyc(IORDY_TMO, CYC_MAX);

  logic [2:0] state_r;
  logic [2:0] state_s;
  logic       cs_sel_r;
  logic       cs_sel_s;
  logic       rw_r;
  logic       rw_s;
  logic [7:0] stretch_r;

  logic       ide_hit_s;
  logic       reg_hit_s;
  logic       start_s;
  logic       tc_s;
  logic       stretch_done_s;
  logic       strobe_done_s;
  logic       tmo_s;
  logic       load_s;
  logic [7:0] load_val_s;

  logic gayle_cs_n_s, cs0_n_s, cs1_n_s, rd_n_s, wr_n_s, buf_oe_n_s, dtack_n_s, timeout_s;
  logic gayle_cs_n_r, cs0_n_r, cs1_n_r, rd_n_r, wr_n_r, buf_oe_n_r, dtack_n_r, timeout_r;

  // Address decode and cycle-start qualification.
  always_comb begin
    ide_hit_s = (bus.A[11:4] == IDE_HI_MATCH) && (bus.A[3:1] == IDE_MID_MATCH);
    reg_hit_s = ((bus.A[11:4] == IDE_HI_MATCH) && bus.A[3]) || (bus.A == REG_ALT_MATCH);
    start_s   = (state_r == ST_IDLE) && !bus.AS_N && !bus.DS_N && (ide_hit_s || reg_hit_s);
    cs_sel_s  = start_s ? bus.A[0] : cs_sel_r;
    rw_s      = start_s ? bus.RW   : rw_r;
  end

  // Strobe exit: ready wins over an expiring stretch, so TIMEOUT only fires
  // when IORDY is still low at the expiry edge.
  always_comb begin
    stretch_done_s = (stretch_r == TMO_LD);
    strobe_done_s  = tc_s && (bus.IORDY || stretch_done_s);
    tmo_s          = (state_r == ST_STROBE) && !bus.AS_N && tc_s && !bus.IORDY && stretch_done_s;
  end

  // Next-state logic; AS_N high aborts any in-flight IDE phase.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_s = reg_hit_s ? ST_REG : ST_SETUP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REG:     state_s = bus.AS_N ? ST_IDLE : ST_REG;
      ST_SETUP: begin
        if (bus.AS_N) begin
          state_s = ST_RECOVER;
        end else if (tc_s) begin
          state_s = ST_STROBE;
        end else begin
          state_s = ST_SETUP;
        end
      end
      ST_STROBE: begin
        if (bus.AS_N) begin
          state_s = ST_RECOVER;
        end else if (strobe_done_s) begin
          state_s = rw_r ? ST_RD_ACK : ST_WR_HOLD;
        end else begin
          state_s = ST_STROBE;
        end
      end
      ST_RD_ACK:  state_s = bus.AS_N ? ST_RECOVER : ST_RD_ACK;
      ST_WR_HOLD: begin
        if (bus.AS_N) begin
          state_s = ST_RECOVER;
        end else if (tc_s) begin
          state_s = ST_WR_ACK;
        end else begin
          state_s = ST_WR_HOLD;
        end
      end
      ST_WR_ACK:  state_s = bus.AS_N ? ST_IDLE : ST_WR_ACK;
      ST_RECOVER: state_s = tc_s ? ST_IDLE : ST_RECOVER;
      default:    state_s = ST_IDLE;
    endcase
  end

  // Counter reload value for the state being entered.
  always_comb begin
    load_s = (state_s != state_r);
    case (state_s)
      ST_REG:     load_val_s = REG_LD;
      ST_SETUP:   load_val_s = SETUP_LD;
      ST_STROBE:  load_val_s = STROBE_LD;
      ST_WR_HOLD: load_val_s = HOLD_LD;
      ST_RECOVER: load_val_s = HOLD_LD;
      default:    load_val_s = 8'd0;
    endcase
  end

  gayle_cyc_counter u_cnt (
    .CLKCPU   (CLKCPU),
    .RESET    (RESET),
    .load     (load_s),
    .load_val (load_val_s),
    .tc       (tc_s)
  );

  // Output values for the upcoming state, registered below so every pin
  // comes straight from a flop.
  always_comb begin
    gayle_cs_n_s = 1'b1;
    cs0_n_s      = 1'b1;
    cs1_n_s      = 1'b1;
    rd_n_s       = 1'b1;
    wr_n_s       = 1'b1;
    buf_oe_n_s   = 1'b1;
    dtack_n_s    = 1'b1;
    timeout_s    = tmo_s;
    case (state_s)
      ST_REG: begin
        gayle_cs_n_s = 1'b0;
        if ((state_r == ST_REG) && tc_s) begin
          dtack_n_s = 1'b0;
        end else begin
          dtack_n_s = 1'b1;
        end
      end
      ST_SETUP, ST_WR_HOLD, ST_RECOVER: begin
        cs0_n_s    = cs_sel_s;
        cs1_n_s    = !cs_sel_s;
        buf_oe_n_s = 1'b0;
      end
      ST_STROBE: begin
        cs0_n_s    = cs_sel_s;
        cs1_n_s    = !cs_sel_s;
        buf_oe_n_s = 1'b0;
        rd_n_s     = !rw_s;
        wr_n_s     = rw_s;
      end
      ST_RD_ACK: begin
        cs0_n_s    = cs_sel_s;
        cs1_n_s    = !cs_sel_s;
        buf_oe_n_s = 1'b0;
        rd_n_s     = 1'b0;
        dtack_n_s  = 1'b0;
      end
      ST_WR_ACK: dtack_n_s = 1'b0;
      default:   timeout_s = tmo_s;
    endcase
  end

  // FSM state and per-cycle latched select/direction.
  always_ff @(posedge CLKCPU or posedge RESET) begin
    if (RESET) begin
      state_r  <= ST_IDLE;
      cs_sel_r <= 1'b0;
      rw_r     <= 1'b1;
    end else begin
      state_r  <= state_s;
      cs_sel_r <= cs_sel_s;
      rw_r     <= rw_s;
    end
  end

  // IORDY stretch counter, cleared on every STROBE entry.
  always_ff @(posedge CLKCPU or posedge RESET) begin
    if (RESET) begin
      stretch_r <= 8'd0;
    end else if ((state_s == ST_STROBE) && (state_r != ST_STROBE)) begin
      stretch_r <= 8'd0;
    end else if ((state_r == ST_STROBE) && tc_s && !bus.IORDY && !stretch_done_s) begin
      stretch_r <= stretch_r + 8'd1;
    end else begin
      stretch_r <= stretch_r;
    end
  end

  // Output registers.
  always_ff @(posedge CLKCPU or posedge RESET) begin
    if (RESET) begin
      gayle_cs_n_r <= 1'b1;
      cs0_n_r      <= 1'b1;
      cs1_n_r      <= 1'b1;
      rd_n_r       <= 1'b1;
      wr_n_r       <= 1'b1;
      buf_oe_n_r   <= 1'b1;
      dtack_n_r    <= 1'b1;
      timeout_r    <= 1'b0;
    end else begin
      gayle_cs_n_r <= gayle_cs_n_s;
      cs0_n_r      <= cs0_n_s;
      cs1_n_r      <= cs1_n_s;
      rd_n_r       <= rd_n_s;
      wr_n_r       <= wr_n_s;
      buf_oe_n_r   <= buf_oe_n_s;
      dtack_n_r    <= dtack_n_s;
      timeout_r    <= timeout_s;
    end
  end

  assign bus.GAYLE_CS_N = gayle_cs_n_r;
  assign bus.IDE_CS0_N  = cs0_n_r;
  assign bus.IDE_CS1_N  = cs1_n_r;
  assign bus.IDE_RD_N   = rd_n_r;
  assign bus.IDE_WR_N   = wr_n_r;
  assign bus.BUF_OE_N   = buf_oe_n_r;
  assign bus.DTACK_N    = dtack_n_r;
  assign bus.TIMEOUT    = timeout_r;

endmodule

// File: tb/tb_gayle_ide_cycle.sv
// Directed bench for gayle_ide_cycle with default timing; every output is
// compared cycle by cycle as the packed vector
// {GAYLE_CS_N, IDE_CS0_N, IDE_CS1_N, IDE_RD_N, IDE_WR_N, BUF_OE_N, DTACK_N, TIMEOUT}.
module tb_gayle_ide_cycle;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic [7:0] outs;

  localparam logic [7:0] V_IDLE     = 8'b1111_1110;
  localparam logic [7:0] V_CS0      = 8'b1011_1010;
  localparam logic [7:0] V_CS0_RD   = 8'b1010_1010;
  localparam logic [7:0] V_CS0_ACK  = 8'b1010_1000;
  localparam logic [7:0] V_CS0_TMO  = 8'b1010_1001;
  localparam logic [7:0] V_CS1      = 8'b1101_1010;
  localparam logic [7:0] V_CS1_WR   = 8'b1101_0010;
  localparam logic [7:0] V_WR_ACK   = 8'b1111_1100;
  localparam logic [7:0] V_REG      = 8'b0111_1110;
  localparam logic [7:0] V_REG_ACK  = 8'b0111_1100;

  gayle_ide_cycle_if bus();

  gayle_ide_cycle dut (
    .CLKCPU (clk),
    .RESET  (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  assign outs = {bus.GAYLE_CS_N, bus.IDE_CS0_N, bus.IDE_CS1_N, bus.IDE_RD_N,
                 bus.IDE_WR_N, bus.BUF_OE_N, bus.DTACK_N, bus.TIMEOUT};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] exp);
    checks++;
    assert (outs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, outs, exp);
    end
  endtask

  task automatic expect_n(input string tag, input logic [7:0] exp, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check(tag, exp);
    end
  endtask

  task automatic bus_start(input logic [11:0] addr, input logic rw);
    bus.A    = addr;
    bus.RW   = rw;
    bus.AS_N = 1'b0;
    bus.DS_N = 1'b0;
  endtask

  task automatic bus_end();
    bus.AS_N = 1'b1;
    bus.DS_N = 1'b1;
  endtask

  task automatic full_read(input string tag);
    bus_start(12'hDA2, 1'b1);
    expect_n({tag, "_setup"}, V_CS0, 2);
    expect_n({tag, "_strobe"}, V_CS0_RD, 6);
    expect_n({tag, "_ack"}, V_CS0_ACK, 2);
    bus_end();
    expect_n({tag, "_recover"}, V_CS0, 2);
    expect_n({tag, "_idle"}, V_IDLE, 1);
  endtask

  initial begin
    rst      = 1'b1;
    bus.AS_N = 1'b1;
    bus.DS_N = 1'b1;
    bus.RW   = 1'b1;
    bus.A    = 12'h000;
    bus.IORDY = 1'b1;
    repeat (2) tick();
    check("reset_state", V_IDLE);
    rst = 1'b0;
    expect_n("idle_after_reset", V_IDLE, 2);

    // Read $DA2000: CS0 cycles 1-2, DIOR cycles 3-8, DTACK cycle 9.
    full_read("read_da2");

    // Write $DA3000: 6 DIOW cycles, 2 hold cycles, then DTACK until AS_N high.
    bus_start(12'hDA3, 1'b0);
    expect_n("write_setup", V_CS1, 2);
    expect_n("write_strobe", V_CS1_WR, 6);
    expect_n("write_hold", V_CS1, 2);
    expect_n("write_ack", V_WR_ACK, 3);
    bus_end();
    expect_n("write_idle", V_IDLE, 2);

    // Gayle register windows.
    bus_start(12'hDA8, 1'b1);
    expect_n("reg_da8_cs", V_REG, 1);
    expect_n("reg_da8_ack", V_REG_ACK, 2);
    bus_end();
    expect_n("reg_da8_idle", V_IDLE, 1);
    bus_start(12'hDE1, 1'b1);
    expect_n("reg_de1_cs", V_REG, 1);
    expect_n("reg_de1_ack", V_REG_ACK, 2);
    bus_end();
    expect_n("reg_de1_idle", V_IDLE, 1);

    // Unmapped address.
    bus_start(12'hC00, 1'b1);
    expect_n("nohit_c00", V_IDLE, 4);
    bus_end();
    expect_n("nohit_idle", V_IDLE, 1);

    // IORDY low for 10 stretch cycles: 16-cycle strobe, no TIMEOUT.
    bus.IORDY = 1'b0;
    bus_start(12'hDA2, 1'b1);
    expect_n("stretch_setup", V_CS0, 2);
    expect_n("stretch_strobe", V_CS0_RD, 16);
    bus.IORDY = 1'b1;
    expect_n("stretch_ack", V_CS0_ACK, 1);
    bus_end();
    expect_n("stretch_recover", V_CS0, 2);
    expect_n("stretch_idle", V_IDLE, 1);

    // IORDY stuck low: 70-cycle strobe and a single TIMEOUT pulse.
    bus.IORDY = 1'b0;
    bus_start(12'hDA2, 1'b1);
    expect_n("tmo_setup", V_CS0, 2);
    expect_n("tmo_strobe", V_CS0_RD, 70);
    expect_n("tmo_pulse", V_CS0_TMO, 1);
    expect_n("tmo_ack", V_CS0_ACK, 1);
    bus_end();
    expect_n("tmo_recover", V_CS0, 2);
    expect_n("tmo_idle", V_IDLE, 1);

    // IORDY rises on the expiry edge: ready, no TIMEOUT.
    bus_start(12'hDA2, 1'b1);
    expect_n("tmo_race_setup", V_CS0, 2);
    expect_n("tmo_race_strobe", V_CS0_RD, 70);
    bus.IORDY = 1'b1;
    expect_n("tmo_race_ack", V_CS0_ACK, 1);
    bus_end();
    expect_n("tmo_race_recover", V_CS0, 2);
    expect_n("tmo_race_idle", V_IDLE, 1);

    // Abort in strobe cycle 2: no DTACK, CS held 2 cycles, next cycle accepted.
    bus_start(12'hDA2, 1'b1);
    expect_n("abort_setup", V_CS0, 2);
    expect_n("abort_strobe", V_CS0_RD, 2);
    bus_end();
    expect_n("abort_recover", V_CS0, 2);
    expect_n("abort_idle", V_IDLE, 1);
    full_read("after_abort");

    // Abort on the strobe-completion edge takes the abort path.
    bus_start(12'hDA2, 1'b1);
    expect_n("abort_tc_setup", V_CS0, 2);
    expect_n("abort_tc_strobe", V_CS0_RD, 6);
    bus_end();
    expect_n("abort_tc_recover", V_CS0, 2);
    expect_n("abort_tc_idle", V_IDLE, 1);

    // RESET mid-strobe takes effect before the next edge.
    bus_start(12'hDA2, 1'b1);
    expect_n("rst_setup", V_CS0, 2);
    expect_n("rst_strobe", V_CS0_RD, 3);
    rst = 1'b1;
    #1;
    check("rst_async", V_IDLE);
    bus_end();
    tick();
    check("rst_held", V_IDLE);
    rst = 1'b0;
    expect_n("rst_release", V_IDLE, 1);
    full_read("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
